// File: rtl/deint_field_router_pkg.sv
// Shared types and helpers for the deinterlacer field router: packet-type codes,
// route and state encodings, and control-packet decoding.
package deint_field_router_pkg;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  typedef enum logic [1:0] {
    ROUTE_DEINT  = 2'd0,
    ROUTE_BYPASS = 2'd1,
    ROUTE_DROP   = 2'd2
  } route_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CAPT   = 3'd1;
  localparam logic [2:0] ST_REPLAY = 3'd2;
  localparam logic [2:0] ST_VIDEO  = 3'd3;
  localparam logic [2:0] ST_DISC   = 3'd4;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [3:0]  interlace;
  } ctrl_info_t;

  // Nibbles arrive most significant first: W[15:12] .. W[3:0], H[15:12] .. H[3:0], I.
  function automatic ctrl_info_t decode_ctrl(input logic [35:0] nibbles);
    ctrl_info_t info;
    info.width     = nibbles[35:20];
    info.height    = nibbles[19:4];
    info.interlace = nibbles[3:0];
    return info;
  endfunction

  function automatic route_t pick_route(input logic [3:0] interlace, input logic bypass_all,
                                        input logic drop_f1);
    if (bypass_all || !interlace[3])
      return ROUTE_BYPASS;
    else if (interlace[2])
      return drop_f1 ? ROUTE_DROP : ROUTE_BYPASS;
    else
      return ROUTE_DEINT;
  endfunction

endpackage

// File: rtl/deint_field_router_if.sv
// Avalon-ST link (ready latency 0) used for the router's sink and both sources.
interface deint_field_router_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  startofpacket;
  logic                  endofpacket;

  modport master (output data, valid, startofpacket, endofpacket, input ready);
  modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/deint_field_router.sv
// Routes each video field to the deinterlacer, the bypass path or nowhere, based on
// the preceding control packet, which is buffered and replayed to the chosen source.
module deint_field_router
  import deint_field_router_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter bit DROP_F1          = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  deint_field_router_if.slave  din,
  deint_field_router_if.master deint,
  deint_field_router_if.master byp,
  input  logic                 cfg_bypass_all,
  output logic [15:0]          stat_width,
  output logic [15:0]          stat_height,
  output logic [1:0]           stat_route,
  output logic [15:0]          stat_f1_dropped
);

  localparam int DATA_WIDTH = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  logic [2:0]            state;
  route_t                route;
  logic                  active;
  logic [DATA_WIDTH-1:0] ctrl_buf [0:3];
  logic [2:0]            cnt;
  logic [1:0]            rptr;
  logic [1:0]            rlast;

  logic [3:0]            pkt_type;
  logic                  replaying;
  logic                  fwd;
  logic                  sel_ready;
  logic                  accept;
  logic [35:0]           ctrl_nib;
  ctrl_info_t            info;
  route_t                new_route;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sop;
  logic                  out_eop;
  logic                  deint_on;
  logic                  byp_on;

  // A sop beat outside REPLAY is always treated as a fresh header; only video
  // beats are forwarded, everything else is absorbed by the router.
  always_comb begin
    pkt_type  = din.data[3:0];
    replaying = (state == ST_REPLAY);
    fwd       = active && !replaying &&
                ((state == ST_VIDEO && !din.startofpacket) ||
                 (din.startofpacket && pkt_type == PKT_VIDEO));
    case (route)
      ROUTE_DEINT:  sel_ready = deint.ready;
      ROUTE_BYPASS: sel_ready = byp.ready;
      default:      sel_ready = 1'b1;
    endcase
    din.ready = active && !replaying && (fwd ? sel_ready : 1'b1);
    accept    = din.valid && din.ready;
  end

  // Nibble view of beats 1..3, with the beat currently on din standing in for
  // the buffer slot it is about to fill so decode can happen on the eop beat.
  always_comb begin
    ctrl_nib = '0;
    for (int b = 1; b < 4; b++) begin
      for (int s = 0; s < 3; s++) begin
        ctrl_nib[35 - 4*((b-1)*3 + s) -: 4] = (cnt == 3'(b)) ?
            din.data[s*BITS_PER_SYMBOL +: 4] : ctrl_buf[b][s*BITS_PER_SYMBOL +: 4];
      end
    end
    info      = decode_ctrl(ctrl_nib);
    new_route = pick_route(info.interlace, cfg_bypass_all, DROP_F1);
  end

  always_comb begin
    out_valid = replaying ? 1'b1 : (fwd && din.valid);
    out_data  = replaying ? ctrl_buf[rptr] : din.data;
    out_sop   = replaying ? (rptr == 2'd0) : din.startofpacket;
    out_eop   = replaying ? (rptr == rlast) : din.endofpacket;
    deint_on  = (route == ROUTE_DEINT) && (replaying || fwd);
    byp_on    = (route == ROUTE_BYPASS) && (replaying || fwd);

    deint.valid         = deint_on && out_valid;
    deint.data          = deint_on ? out_data : '0;
    deint.startofpacket = deint_on && out_sop;
    deint.endofpacket   = deint_on && out_eop;

    byp.valid           = byp_on && out_valid;
    byp.data            = byp_on ? out_data : '0;
    byp.startofpacket   = byp_on && out_sop;
    byp.endofpacket     = byp_on && out_eop;
  end

  // stat_route is updated alongside route but resets to 0 so every status
  // output reads zero straight out of reset, even though route starts as bypass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      route           <= ROUTE_BYPASS;
      active          <= 1'b0;
      cnt             <= '0;
      rptr            <= '0;
      rlast           <= '0;
      stat_width      <= '0;
      stat_height     <= '0;
      stat_route      <= '0;
      stat_f1_dropped <= '0;
      for (int i = 0; i < 4; i++) ctrl_buf[i] <= '0;
    end else begin
      active <= 1'b1;
      if (replaying) begin
        if (sel_ready) begin
          if (rptr == rlast) state <= ST_IDLE;
          else               rptr  <= rptr + 2'd1;
        end
      end else if (accept) begin
        if (din.startofpacket) begin
          case (pkt_type)
            PKT_CTRL: begin
              ctrl_buf[0] <= din.data;
              cnt         <= 3'd1;
              rptr        <= '0;
              if (din.endofpacket) begin
                route      <= ROUTE_BYPASS;
                stat_route <= ROUTE_BYPASS;
                rlast      <= 2'd0;
                state      <= ST_REPLAY;
              end else begin
                state <= ST_CAPT;
              end
            end
            PKT_VIDEO: begin
              if (din.endofpacket) begin
                state <= ST_IDLE;
                if (route == ROUTE_DROP) stat_f1_dropped <= stat_f1_dropped + 16'd1;
              end else begin
                state <= ST_VIDEO;
              end
            end
            default: state <= din.endofpacket ? ST_IDLE : ST_DISC;
          endcase
        end else begin
          case (state)
            ST_CAPT: begin
              if (cnt < 3'd4) begin
                ctrl_buf[cnt[1:0]] <= din.data;
                cnt                <= cnt + 3'd1;
              end
              if (din.endofpacket) begin
                rptr <= '0;
                if (cnt >= 3'd3) begin
                  stat_width  <= info.width;
                  stat_height <= info.height;
                  route       <= new_route;
                  stat_route  <= new_route;
                  rlast       <= 2'd3;
                  state       <= (new_route == ROUTE_DROP) ? ST_IDLE : ST_REPLAY;
                end else begin
                  route      <= ROUTE_BYPASS;
                  stat_route <= ROUTE_BYPASS;
                  rlast      <= cnt[1:0];
                  state      <= ST_REPLAY;
                end
              end
            end
            ST_VIDEO: begin
              if (din.endofpacket) begin
                state <= ST_IDLE;
                if (route == ROUTE_DROP) stat_f1_dropped <= stat_f1_dropped + 16'd1;
              end
            end
            ST_DISC: begin
              if (din.endofpacket) state <= ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_deint_field_router.sv
// Directed bench for deint_field_router: control decode, routing, F1 drop,
// backpressure, user packets and mid-packet reset, checked against scoreboards.
module tb_deint_field_router;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_bypass_all;
  logic [15:0] stat_width;
  logic [15:0] stat_height;
  logic [1:0]  stat_route;
  logic [15:0] stat_f1_dropped;

  always #5 clock = ~clock;

  deint_field_router_if #(.DATA_WIDTH(24)) din_bus ();
  deint_field_router_if #(.DATA_WIDTH(24)) deint_bus ();
  deint_field_router_if #(.DATA_WIDTH(24)) byp_bus ();

  deint_field_router #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(3),
    .DROP_F1         (1'b1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .din            (din_bus),
    .deint          (deint_bus),
    .byp            (byp_bus),
    .cfg_bypass_all (cfg_bypass_all),
    .stat_width     (stat_width),
    .stat_height    (stat_height),
    .stat_route     (stat_route),
    .stat_f1_dropped(stat_f1_dropped)
  );

  int          cmp_count = 0;
  int          err_count = 0;
  int          deint_valid_cycles = 0;
  int          byp_valid_cycles = 0;
  int          din_stall_cycles = 0;
  logic        bp_en = 1'b0;
  logic        deint_stalled = 1'b0;
  logic [25:0] deint_prev = '0;
  logic [25:0] exp_deint[$];
  logic [25:0] exp_byp[$];
  logic [25:0] obs_deint[$];
  logic [25:0] obs_byp[$];
  logic [23:0] pkt[$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    cmp_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Monitor samples mid-cycle; inputs only change just after the rising edge.
  always @(negedge clock) begin
    if (deint_bus.valid) deint_valid_cycles++;
    if (byp_bus.valid) byp_valid_cycles++;
    if (din_bus.valid && !din_bus.ready) din_stall_cycles++;
    if (deint_bus.valid && deint_bus.ready)
      obs_deint.push_back({deint_bus.startofpacket, deint_bus.endofpacket, deint_bus.data});
    if (byp_bus.valid && byp_bus.ready)
      obs_byp.push_back({byp_bus.startofpacket, byp_bus.endofpacket, byp_bus.data});
    if (deint_stalled && !reset)
      checkOutput("deint_hold", {deint_bus.valid, deint_bus.startofpacket, deint_bus.endofpacket,
                                 deint_bus.data}, {1'b1, deint_prev});
    deint_stalled = deint_bus.valid && !deint_bus.ready && !reset;
    deint_prev    = {deint_bus.startofpacket, deint_bus.endofpacket, deint_bus.data};
  end

  initial begin
    byp_bus.ready   = 1'b1;
    deint_bus.ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      deint_bus.ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clearCounters();
    deint_valid_cycles = 0;
    byp_valid_cycles   = 0;
    din_stall_cycles   = 0;
  endtask

  // dest: 0 deinterlacer, 1 bypass, 2 nowhere. Called just after a rising edge.
  task automatic sendBeat(input logic [23:0] data, input logic sop, input logic eop, input int dest);
    int waited = 0;
    din_bus.data          = data;
    din_bus.valid         = 1'b1;
    din_bus.startofpacket = sop;
    din_bus.endofpacket   = eop;
    @(negedge clock);
    while (!din_bus.ready && waited < 300) begin
      waited++;
      @(negedge clock);
    end
    checkOutput("din_accept", din_bus.ready, 1'b1);
    if (din_bus.ready) begin
      if (dest == 0) exp_deint.push_back({sop, eop, data});
      else if (dest == 1) exp_byp.push_back({sop, eop, data});
    end
    @(posedge clock);
    #1;
    din_bus.valid         = 1'b0;
    din_bus.startofpacket = 1'b0;
    din_bus.endofpacket   = 1'b0;
  endtask

  task automatic applyStimulus(input int dest);
    for (int i = 0; i < pkt.size(); i++)
      sendBeat(pkt[i], i == 0, i == pkt.size() - 1, dest);
  endtask

  task automatic makeCtrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    pkt.delete();
    pkt.push_back(24'hA5A50F);
    pkt.push_back({4'hA, w[7:4], 4'h5, w[11:8], 4'hC, w[15:12]});
    pkt.push_back({4'h3, h[11:8], 4'h9, h[15:12], 4'h6, w[3:0]});
    pkt.push_back({4'hB, il, 4'h1, h[3:0], 4'hE, h[7:4]});
  endtask

  task automatic makeVideo(input int n, input logic [23:0] base);
    pkt.delete();
    pkt.push_back(24'h777770);
    for (int i = 0; i < n; i++) pkt.push_back(base + 24'(i));
  endtask

  task automatic checkScoreboard(input string tag);
    checkOutput({tag, "_deint_count"}, obs_deint.size(), exp_deint.size());
    for (int i = 0; i < obs_deint.size() && i < exp_deint.size(); i++)
      checkOutput({tag, "_deint_beat"}, obs_deint[i], exp_deint[i]);
    checkOutput({tag, "_byp_count"}, obs_byp.size(), exp_byp.size());
    for (int i = 0; i < obs_byp.size() && i < exp_byp.size(); i++)
      checkOutput({tag, "_byp_beat"}, obs_byp[i], exp_byp[i]);
    obs_deint.delete();
    exp_deint.delete();
    obs_byp.delete();
    exp_byp.delete();
  endtask

  initial begin
    reset                 = 1'b1;
    cfg_bypass_all        = 1'b0;
    din_bus.valid         = 1'b0;
    din_bus.data          = '0;
    din_bus.startofpacket = 1'b0;
    din_bus.endofpacket   = 1'b0;
    idleCycles(3);

    checkOutput("rst_din_ready", din_bus.ready, 1'b0);
    checkOutput("rst_deint_valid", deint_bus.valid, 1'b0);
    checkOutput("rst_byp_valid", byp_bus.valid, 1'b0);
    checkOutput("rst_deint_data", deint_bus.data, 24'h0);
    checkOutput("rst_stat_width", stat_width, 16'h0);
    checkOutput("rst_stat_route", stat_route, 2'd0);
    checkOutput("rst_f1_dropped", stat_f1_dropped, 16'h0);
    reset = 1'b0;
    idleCycles(2);

    $display("[TB] test 1: interlaced F0 to deinterlacer");
    clearCounters();
    makeCtrl(16'd640, 16'd240, 4'b1000);
    applyStimulus(0);
    makeVideo(6, 24'h100000);
    applyStimulus(0);
    idleCycles(8);
    checkScoreboard("t1");
    checkOutput("t1_byp_valid_cycles", byp_valid_cycles, 0);
    checkOutput("t1_stat_route", stat_route, 2'd0);
    checkOutput("t1_stat_width", stat_width, 16'd640);
    checkOutput("t1_stat_height", stat_height, 16'd240);

    $display("[TB] test 2: interlaced F1 dropped");
    clearCounters();
    makeCtrl(16'd640, 16'd240, 4'b1100);
    applyStimulus(2);
    idleCycles(3);
    checkOutput("t2_stat_route", stat_route, 2'd2);
    checkOutput("t2_f1_before", stat_f1_dropped, 16'd0);
    makeVideo(6, 24'h200000);
    applyStimulus(2);
    idleCycles(3);
    checkOutput("t2_f1_after", stat_f1_dropped, 16'd1);
    checkOutput("t2_din_stalls", din_stall_cycles, 0);
    checkOutput("t2_deint_valid_cycles", deint_valid_cycles, 0);
    checkOutput("t2_byp_valid_cycles", byp_valid_cycles, 0);
    checkScoreboard("t2");

    $display("[TB] test 3: progressive to bypass");
    clearCounters();
    makeCtrl(16'd320, 16'd240, 4'b0000);
    applyStimulus(1);
    makeVideo(5, 24'h300000);
    applyStimulus(1);
    idleCycles(8);
    checkScoreboard("t3");
    checkOutput("t3_deint_valid_cycles", deint_valid_cycles, 0);
    checkOutput("t3_stat_route", stat_route, 2'd1);
    checkOutput("t3_stat_width", stat_width, 16'd320);

    $display("[TB] test 4: deinterlacer backpressure");
    clearCounters();
    bp_en = 1'b1;
    makeCtrl(16'd16, 16'd8, 4'b1000);
    applyStimulus(0);
    makeVideo(20, 24'h400000);
    applyStimulus(0);
    idleCycles(40);
    bp_en = 1'b0;
    idleCycles(2);
    checkScoreboard("t4");
    checkOutput("t4_byp_valid_cycles", byp_valid_cycles, 0);

    $display("[TB] test 5: user packet consumed");
    clearCounters();
    pkt.delete();
    pkt.push_back(24'h123453);
    for (int i = 0; i < 4; i++) pkt.push_back(24'h500000 + 24'(i));
    applyStimulus(2);
    idleCycles(3);
    checkOutput("t5_user_deint_cycles", deint_valid_cycles, 0);
    checkOutput("t5_user_byp_cycles", byp_valid_cycles, 0);
    makeCtrl(16'd32, 16'd16, 4'b1000);
    applyStimulus(0);
    makeVideo(4, 24'h510000);
    applyStimulus(0);
    idleCycles(8);
    checkScoreboard("t5");
    checkOutput("t5_stat_width", stat_width, 16'd32);
    checkOutput("t5_stat_route", stat_route, 2'd0);

    $display("[TB] test 6: reset mid-video");
    makeVideo(150, 24'h600000);
    for (int i = 0; i < 100; i++) sendBeat(pkt[i], i == 0, 1'b0, 0);
    din_bus.data  = pkt[100];
    din_bus.valid = 1'b1;
    #2;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t6_deint_valid", deint_bus.valid, 1'b0);
    checkOutput("t6_deint_data", deint_bus.data, 24'h0);
    checkOutput("t6_deint_sop", deint_bus.startofpacket, 1'b0);
    checkOutput("t6_byp_valid", byp_bus.valid, 1'b0);
    checkOutput("t6_din_ready", din_bus.ready, 1'b0);
    checkOutput("t6_stat_width", stat_width, 16'h0);
    checkOutput("t6_stat_height", stat_height, 16'h0);
    checkOutput("t6_stat_route", stat_route, 2'd0);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    din_bus.valid = 1'b0;
    clearCounters();
    for (int i = 101; i < 110; i++) sendBeat(pkt[i], 1'b0, i == 109, 2);
    idleCycles(3);
    checkOutput("t6_discard_deint_cycles", deint_valid_cycles, 0);
    checkOutput("t6_discard_byp_cycles", byp_valid_cycles, 0);
    checkScoreboard("t6a");
    clearCounters();
    cfg_bypass_all = 1'b1;
    makeCtrl(16'd64, 16'd32, 4'b1000);
    applyStimulus(1);
    makeVideo(3, 24'h610000);
    applyStimulus(1);
    idleCycles(8);
    checkScoreboard("t6b");
    checkOutput("t6_forced_route", stat_route, 2'd1);
    checkOutput("t6_forced_deint_cycles", deint_valid_cycles, 0);
    checkOutput("t6_forced_width", stat_width, 16'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
